// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - I2S stereo transmitter with one-entry sample buffer and PLL-lock gating
module i2s_audio_tx #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              i2s_bclk,
    output logic              i2s_lrck,
    output logic              i2s_data,
    output logic              underrun
);
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int HC_W    = $clog2(BCLK_DIV);
    localparam int BC_W    = $clog2(FRAME_W);

    localparam logic [HC_W-1:0] HC_MAX = HC_W'(BCLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(FRAME_W - 1);
    localparam logic [BC_W-1:0] LR_LO  = BC_W'(SLOT_W - 1);
    localparam logic [BC_W-1:0] LR_HI  = BC_W'(FRAME_W - 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_next;
    logic                sync_meta, lock_s;
    logic [HC_W-1:0]     hc;
    logic [BC_W-1:0]     bc;
    logic                started;
    logic                buf_full;
    logic [DATA_W-1:0]   buf_left, buf_right;
    logic [FRAME_W-1:0]  tx_sr;

    logic                run_ok;
    logic                evt;
    logic [BC_W-1:0]     bit_idx;
    logic                frame_start;
    logic                transfer;
    logic                full_next;
    logic [FRAME_W-1:0]  frame_word;
    logic [FRAME_W-1:0]  load_word;

    // Two-flop synchronizer for the asynchronous PLL lock flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            sync_meta <= pll_locked;
            lock_s    <= sync_meta;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state: run only while the synchronized lock is held
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (lock_s)  state_next = RUN;
            RUN:     if (!lock_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Event decode: first live RUN cycle, or the cycle BCLK falls
    always_comb begin
        run_ok      = (state == RUN) && lock_s;
        evt         = run_ok && (!started || (i2s_bclk && (hc == HC_MAX)));
        bit_idx     = (!started || (bc == BC_MAX)) ? '0 : bc + BC_W'(1);
        frame_start = evt && (bit_idx == '0);
        transfer    = s_valid && s_ready;
        full_next   = buf_full;
        if (transfer)                    full_next = 1'b1;
        else if (frame_start && buf_full) full_next = 1'b0;
        // Slot layout: left MSB-aligned in slot 0, right MSB-aligned in slot 1
        frame_word  = (FRAME_W'(buf_left)  << (FRAME_W - DATA_W))
                    | (FRAME_W'(buf_right) << (SLOT_W - DATA_W));
        load_word   = buf_full ? frame_word : '0;
    end

    // Datapath: BCLK divider, bit counter, buffer, serializer; everything clears outside RUN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hc        <= '0;
            bc        <= '0;
            started   <= 1'b0;
            buf_full  <= 1'b0;
            buf_left  <= '0;
            buf_right <= '0;
            tx_sr     <= '0;
            s_ready   <= 1'b0;
            i2s_bclk  <= 1'b0;
            i2s_lrck  <= 1'b0;
            i2s_data  <= 1'b0;
            underrun  <= 1'b0;
        end else if (!run_ok) begin
            hc        <= '0;
            bc        <= '0;
            started   <= 1'b0;
            buf_full  <= 1'b0;
            buf_left  <= '0;
            buf_right <= '0;
            tx_sr     <= '0;
            s_ready   <= 1'b0;
            i2s_bclk  <= 1'b0;
            i2s_lrck  <= 1'b0;
            i2s_data  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            hc <= (hc == HC_MAX) ? '0 : hc + HC_W'(1);
            if (hc == HC_MAX) i2s_bclk <= ~i2s_bclk;

            buf_full <= full_next;
            if (transfer) begin
                buf_left  <= s_left;
                buf_right <= s_right;
            end
            // Ready reflects next-cycle occupancy so a transfer can never overwrite
            s_ready  <= !full_next;
            underrun <= frame_start && !buf_full;

            if (evt) begin
                started  <= 1'b1;
                bc       <= bit_idx;
                i2s_lrck <= (bit_idx >= LR_LO) && (bit_idx <= LR_HI);
                if (frame_start) begin
                    i2s_data <= load_word[FRAME_W-1];
                    tx_sr    <= load_word << 1;
                end else begin
                    i2s_data <= tx_sr[FRAME_W-1];
                    tx_sr    <= tx_sr << 1;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - self-checking bench for i2s_audio_tx with a frame-decoding reference model
module tb_i2s_audio_tx;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0, pll_locked = 1'b0, s_valid = 1'b0, s_ready;
    logic [23:0] s_left = '0, s_right = '0;
    logic        i2s_bclk, i2s_lrck, i2s_data, underrun;

    logic        pll_locked2 = 1'b0, s_valid2 = 1'b0, s_ready2;
    logic [15:0] s_left2 = '0, s_right2 = '0;
    logic        bclk2, lrck2, data2, underrun2;

    int total = 0;
    int bad   = 0;

    i2s_audio_tx dut (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked),
        .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data), .underrun(underrun)
    );

    i2s_audio_tx #(.DATA_W(16), .SLOT_W(16), .BCLK_DIV(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked2),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_left(s_left2), .s_right(s_right2),
        .i2s_bclk(bclk2), .i2s_lrck(lrck2), .i2s_data(data2), .underrun(underrun2)
    );

    typedef struct {
        logic [63:0] bits;
        logic [63:0] lr;
        bit          ur;
    } frame_t;

    frame_t      frame_q[$];
    logic [47:0] acc_q[$];
    bit          mon_clr = 1'b1;
    int          mon_idx = 0;
    bit          mon_ur = 1'b0;
    logic [63:0] mon_bits = '0, mon_lr = '0;
    int          ur_len = 0, ur_bad_len = 0, stable_viol = 0;
    logic        prev_bclk = 1'b0, prev_data = 1'b0, prev_lr = 1'b0;

    // Receiver model: latch each bit on BCLK rise, bit b of a frame lands at [63-b]
    always @(negedge clk) begin
        if (mon_clr) begin
            mon_idx = 0; mon_ur = 1'b0; mon_bits = '0; mon_lr = '0; ur_len = 0;
            frame_q.delete();
            acc_q.delete();
            prev_bclk = 1'b0;
        end else begin
            if (i2s_bclk && prev_bclk && (i2s_data !== prev_data || i2s_lrck !== prev_lr))
                stable_viol++;
            if (underrun === 1'b1) begin
                mon_ur = 1'b1; ur_len++;
            end else begin
                if (ur_len > 1) ur_bad_len++;
                ur_len = 0;
            end
            if (i2s_bclk && !prev_bclk) begin
                mon_bits[63-mon_idx] = i2s_data;
                mon_lr[63-mon_idx]   = i2s_lrck;
                mon_idx++;
                if (mon_idx == 64) begin
                    frame_q.push_back('{mon_bits, mon_lr, mon_ur});
                    mon_ur = 1'b0; mon_idx = 0;
                end
            end
            if (s_valid && s_ready) acc_q.push_back({s_left, s_right});
            prev_bclk = i2s_bclk;
        end
        prev_data = i2s_data;
        prev_lr   = i2s_lrck;
    end

    function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
        return {l, 8'h00, r, 8'h00};
    endfunction

    function automatic logic [63:0] exp_lr();
        logic [63:0] m = '0;
        for (int b = 31; b <= 62; b++) m[63-b] = 1'b1;
        return m;
    endfunction

    task automatic wait_frame(output frame_t f);
        int n = 0;
        while (frame_q.size() == 0 && n < 3000) begin @(negedge clk); n++; end
        if (frame_q.size() == 0) begin
            total++; bad++;
            $display("FAIL frame_timeout: no frame after %0d cycles, required one", n);
            f = '{bits: '0, lr: '0, ur: 1'b0};
        end else begin
            f = frame_q.pop_front();
        end
    endtask

    task automatic send_sample(input logic [23:0] l, input logic [23:0] r);
        int n = 0;
        @(posedge clk); #1;
        s_left = l; s_right = r; s_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!s_ready && n < 3000);
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, n);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        mon_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({s_ready, i2s_bclk, i2s_lrck, i2s_data, underrun} !== 5'b0) begin
            bad++;
            $display("FAIL reset_state: outputs=%b required 00000",
                     {s_ready, i2s_bclk, i2s_lrck, i2s_data, underrun});
        end
        #1 reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if ({s_ready, i2s_bclk, i2s_lrck, i2s_data, underrun} !== 5'b0) begin
                bad++;
                $display("FAIL unlocked_idle: cycle %0d outputs=%b required 00000", i,
                         {s_ready, i2s_bclk, i2s_lrck, i2s_data, underrun});
            end
        end
    endtask

    task automatic test_lock();
        int n = 0, t0 = 0, t1 = 0;
        logic pb;
        @(posedge clk); #1;
        pll_locked = 1'b1; mon_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (s_ready !== 1'b0) begin
            bad++; $display("FAIL ready_early: s_ready=%b 3 cycles after lock, required 0", s_ready);
        end
        @(posedge clk); @(negedge clk);
        total++;
        if (s_ready !== 1'b1) begin
            bad++; $display("FAIL ready_latency: s_ready=%b 4 cycles after lock, required 1", s_ready);
        end
        pb = i2s_bclk;
        while (t1 == 0 && n < 200) begin
            @(negedge clk); n++;
            if (i2s_bclk && !pb) begin
                if (t0 == 0) t0 = n; else t1 = n;
            end
            pb = i2s_bclk;
        end
        total++;
        if (t1 == 0 || (t1 - t0) != 32) begin
            bad++; $display("FAIL bclk_period: measured %0d cycles, required 32", t1 - t0);
        end
    endtask

    task automatic test_single_frame();
        frame_t f;
        send_sample(24'hA5C3F0, 24'h0F1E2D);
        wait_frame(f);
        total++;
        if (f.ur !== 1'b1 || f.bits !== 64'h0 || f.lr !== exp_lr()) begin
            bad++;
            $display("FAIL first_frame: ur=%b bits=%h lr=%h, required ur=1 bits=0 lr=%h",
                     f.ur, f.bits, f.lr, exp_lr());
        end
        wait_frame(f);
        total++;
        if (f.ur !== 1'b0 || f.bits !== exp_frame(24'hA5C3F0, 24'h0F1E2D)) begin
            bad++;
            $display("FAIL single_frame: ur=%b bits=%h, required ur=0 bits=%h",
                     f.ur, f.bits, exp_frame(24'hA5C3F0, 24'h0F1E2D));
        end
        total++;
        if (f.lr !== exp_lr()) begin
            bad++; $display("FAIL single_lrck: lr=%h required %h", f.lr, exp_lr());
        end
        if (acc_q.size() > 0) void'(acc_q.pop_front());
    endtask

    task automatic test_underrun();
        frame_t f;
        wait_frame(f);
        total++;
        if (f.ur !== 1'b1 || f.bits !== 64'h0) begin
            bad++; $display("FAIL underrun_frame: ur=%b bits=%h, required ur=1 bits=0", f.ur, f.bits);
        end
        total++;
        if (ur_bad_len !== 0) begin
            bad++; $display("FAIL underrun_width: %0d long pulses, required 0", ur_bad_len);
        end
    endtask

    task automatic test_back_to_back();
        frame_t      f;
        logic [23:0] base, v;
        logic [47:0] a;
        int          k = 0, cyc = 0;
        bit          took;
        base = 24'($urandom);
        @(posedge clk); #1;
        s_valid = 1'b1; s_left = base; s_right = ~base;
        while (frame_q.size() < 4 && cyc < 12000) begin
            @(negedge clk); took = s_ready; cyc++;
            @(posedge clk); #1;
            if (took) begin
                k++; v = base + 24'(k);
                s_left = v; s_right = ~v;
            end
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_frame(f);
            a = (acc_q.size() > 0) ? acc_q.pop_front() : 48'hX;
            total++;
            if (f.ur !== 1'b0 || f.bits !== exp_frame(a[47:24], a[23:0])) begin
                bad++;
                $display("FAIL b2b_frame%0d: ur=%b bits=%h, required ur=0 bits=%h",
                         i, f.ur, f.bits, exp_frame(a[47:24], a[23:0]));
            end
        end
        total++;
        if (acc_q.size() != 1) begin
            bad++; $display("FAIL b2b_transfers: %0d pending transfers, required 1", acc_q.size());
        end
    endtask

    task automatic test_lock_loss();
        frame_t f;
        int     n = 0;
        while (mon_idx != 40 && n < 5000) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        pll_locked = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({s_ready, i2s_bclk, i2s_lrck, i2s_data, underrun} !== 5'b0) begin
            bad++;
            $display("FAIL lockloss_outputs: outputs=%b 3 cycles after lock loss, required 00000",
                     {s_ready, i2s_bclk, i2s_lrck, i2s_data, underrun});
        end
        mon_clr = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if ({s_ready, i2s_bclk, i2s_lrck, i2s_data, underrun} !== 5'b0) begin
            bad++;
            $display("FAIL lockloss_idle: outputs=%b required 00000",
                     {s_ready, i2s_bclk, i2s_lrck, i2s_data, underrun});
        end
        @(posedge clk); #1;
        pll_locked = 1'b1; mon_clr = 1'b0;
        wait_frame(f);
        total++;
        if (f.ur !== 1'b1 || f.bits !== 64'h0 || f.lr !== exp_lr()) begin
            bad++;
            $display("FAIL relock_frame: ur=%b bits=%h lr=%h, required ur=1 bits=0 lr=%h",
                     f.ur, f.bits, f.lr, exp_lr());
        end
    endtask

    task automatic test_async_reset();
        frame_t f;
        int     n = 0;
        while (mon_idx != 20 && n < 5000) begin @(negedge clk); n++; end
        send_sample(24'($urandom), 24'($urandom));
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        total++;
        if ({s_ready, i2s_bclk, i2s_lrck, i2s_data, underrun} !== 5'b0) begin
            bad++;
            $display("FAIL async_reset: outputs=%b before next edge, required 00000",
                     {s_ready, i2s_bclk, i2s_lrck, i2s_data, underrun});
        end
        mon_clr = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b1; mon_clr = 1'b0;
        wait_frame(f);
        total++;
        if (f.ur !== 1'b1 || f.bits !== 64'h0) begin
            bad++;
            $display("FAIL reset_flush: ur=%b bits=%h, required ur=1 bits=0 (buffer lost)", f.ur, f.bits);
        end
    endtask

    task automatic test_small_params();
        logic [15:0] l, r;
        logic [63:0] bits = '0, lr = '0, m = '0;
        int          t0 = 0, t1 = 0, urc = 0;
        l = 16'($urandom); r = 16'($urandom);
        for (int fr = 0; fr < 2; fr++)
            for (int b = 15; b <= 30; b++) m[63-(32*fr+b)] = 1'b1;
        @(posedge clk); #1;
        pll_locked2 = 1'b1;
        fork
            begin
                int  n = 0, idx = 0;
                logic pb = 1'b0;
                while (idx < 64 && n < 1000) begin
                    @(negedge clk); n++;
                    if (underrun2 === 1'b1) urc++;
                    if (bclk2 && !pb) begin
                        if (idx == 0) t0 = n;
                        if (idx == 1) t1 = n;
                        bits[63-idx] = data2; lr[63-idx] = lrck2; idx++;
                    end
                    pb = bclk2;
                end
            end
            begin
                int n = 0;
                s_left2 = l; s_right2 = r; s_valid2 = 1'b1;
                do begin @(negedge clk); n++; end while (!s_ready2 && n < 100);
                @(posedge clk); #1;
                s_valid2 = 1'b0;
            end
        join
        total++;
        if ((t1 - t0) != 4) begin
            bad++; $display("FAIL small_period: measured %0d cycles, required 4", t1 - t0);
        end
        total++;
        if (bits !== {32'h0, l, r}) begin
            bad++; $display("FAIL small_frames: bits=%h required %h", bits, {32'h0, l, r});
        end
        total++;
        if (lr !== m) begin
            bad++; $display("FAIL small_lrck: lr=%h required %h", lr, m);
        end
        total++;
        if (urc != 1) begin
            bad++; $display("FAIL small_underrun: %0d underrun cycles, required 1", urc);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_frame();
        test_underrun();
        test_back_to_back();
        test_lock_loss();
        test_async_reset();
        test_small_params();
        total++;
        if (stable_viol != 0) begin
            bad++; $display("FAIL high_phase_stable: %0d changes while BCLK high, required 0", stable_viol);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
